// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared funct3 and state encodings for the load/store unit
package rv_pkg;

  // RV32I load/store width selectors; stores only use the first three
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering, load extension and legality checks
module lsu_align
  import rv_pkg::*;
(
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_addr_lo,
  input  logic [31:0] req_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  output logic        req_bad,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic illegal;
  logic misal;
  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  // Decode the incoming request: lane enables, replicated store data, error cause
  always_comb begin
    st_be    = 4'b0000;
    st_wdata = 32'h0;
    illegal  = 1'b1;
    misal    = 1'b0;
    case (req_funct3)
      F3_B, F3_BU: begin
        illegal = req_store && (req_funct3 == F3_BU);
        st_be   = 4'b0001 << req_addr_lo;
        if (req_store) st_wdata = {4{req_wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        illegal = req_store && (req_funct3 == F3_HU);
        misal   = req_addr_lo[0];
        st_be   = 4'b0011 << {req_addr_lo[1], 1'b0};
        if (req_store) st_wdata = {2{req_wdata[15:0]}};
      end
      F3_W: begin
        illegal = 1'b0;
        misal   = |req_addr_lo;
        st_be   = 4'b1111;
        if (req_store) st_wdata = req_wdata;
      end
      default: illegal = 1'b1;
    endcase
    req_bad = illegal | misal;
  end

  // Pull the addressed lane down to bit 0 and extend it per the latched funct3
  always_comb begin
    byte_sh = ld_rdata >> {ld_addr_lo, 3'b000};
    half_sh = ld_rdata >> {ld_addr_lo[1], 4'b0000};
    case (ld_funct3)
      F3_B:    ld_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
      F3_BU:   ld_data = {24'h0, byte_sh[7:0]};
      F3_H:    ld_data = {{16{half_sh[15]}}, half_sh[15:0]};
      F3_HU:   ld_data = {16'h0, half_sh[15:0]};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding data memory initiator for the core
module load_store_unit
  import rv_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_e state_q, state_d;

  logic        store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lo_q;
  logic [29:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [CW-1:0] cnt_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic        req_bad;
  logic [31:0] ld_data;

  lsu_align u_align (
    .req_store   (req_store),
    .req_funct3  (req_funct3),
    .req_addr_lo (req_addr[1:0]),
    .req_wdata   (req_wdata),
    .st_be       (st_be),
    .st_wdata    (st_wdata),
    .req_bad     (req_bad),
    .ld_funct3   (funct3_q),
    .ld_addr_lo  (lo_q),
    .ld_rdata    (mem_rdata),
    .ld_data     (ld_data)
  );

  // State register; reset drops mem_req straight away since it decodes state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: bad requests skip the memory; ack beats the final timeout cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = req_bad ? ST_RESP : ST_REQ;
      ST_REQ:  if (mem_ack || (cnt_q == CNT_LAST)) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch, timeout counter and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q  <= 1'b0;
      funct3_q <= 3'b000;
      lo_q     <= 2'b00;
      addr_q   <= 30'h0;
      be_q     <= 4'b0000;
      wdata_q  <= 32'h0;
      cnt_q    <= '0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            store_q  <= req_store;
            funct3_q <= req_funct3;
            lo_q     <= req_addr[1:0];
            addr_q   <= req_addr[31:2];
            be_q     <= st_be;
            wdata_q  <= st_wdata;
            cnt_q    <= '0;
            rdata_q  <= 32'h0;
            err_q    <= req_bad;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            rdata_q <= store_q ? 32'h0 : ld_data;
            err_q   <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign mem_req    = (state_q == ST_REQ);
  assign mem_we     = mem_req & store_q;
  assign mem_addr   = mem_req ? addr_q  : 30'h0;
  assign mem_be     = mem_req ? be_q    : 4'b0000;
  assign mem_wdata  = mem_req ? wdata_q : 32'h0;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed scoreboard bench for load_store_unit
module tb_load_store_unit;
  import rv_pkg::*;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic        model_ack;
  logic        force_ack;
  bit          mem_en;
  int          mem_lat;
  int          wcnt;
  logic [31:0] mem [0:255];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int total;
  int bad;

  logic [29:0] cap_addr;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata;
  logic        cap_we;
  int          req_cycles;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_ack = model_ack | force_ack;

  // Memory model: acks on the mem_lat-th cycle of a request, applies byte-enabled writes
  always @(negedge clk) begin
    if (mem_req && mem_en) begin
      if (wcnt == mem_lat - 1) begin
        model_ack <= 1'b1;
        wcnt      <= 0;
        mem_rdata <= mem[mem_addr[7:0]];
        if (mem_we)
          for (int i = 0; i < 4; i++)
            if (mem_be[i]) mem[mem_addr[7:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
      end else begin
        model_ack <= 1'b0;
        wcnt      <= wcnt + 1;
      end
    end else begin
      model_ack <= 1'b0;
      wcnt      <= 0;
      mem_rdata <= 32'h0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request, push its expected response, then watch the DUT until it answers
  task automatic txn(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rd,
                     input bit exp_err, input int exp_lat, input bit hold);
    exp_t e;
    int   n;
    bit   got;
    bit   rdy_ok;
    bit   stable_ok;
    bit   quiet_ok;
    @(negedge clk);
    chk("ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    sb.push_back('{exp_rd, exp_err, exp_lat});
    n = 0; got = 0; rdy_ok = 1; stable_ok = 1; quiet_ok = 1; req_cycles = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (!hold) req_valid = 1'b0;
      else if (n == 1) begin
        req_store  = 1'b1;
        req_funct3 = F3_W;
        req_addr   = 32'h10;
        req_wdata  = 32'hDEADBEEF;
      end
      if (req_ready) rdy_ok = 0;
      if (mem_req) begin
        if (req_cycles == 0) begin
          cap_addr = mem_addr; cap_be = mem_be; cap_wdata = mem_wdata; cap_we = mem_we;
        end else if (mem_addr !== cap_addr || mem_be !== cap_be ||
                     mem_wdata !== cap_wdata || mem_we !== cap_we) begin
          stable_ok = 0;
        end
        req_cycles++;
      end else if (mem_be !== 4'h0 || mem_addr !== 30'h0 || mem_wdata !== 32'h0 || mem_we !== 1'b0) begin
        quiet_ok = 0;
      end
      if (resp_valid) begin
        got = 1;
        req_valid = 1'b0;
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", 32'(resp_err), 32'(e.err));
        chk("resp_latency", 32'(n), 32'(e.lat));
      end
    end
    if (!got) begin
      chk("resp_seen", 32'd0, 32'd1);
      void'(sb.pop_front());
      req_valid = 1'b0;
    end
    chk("ready_low_busy", 32'(rdy_ok), 32'd1);
    chk("mem_stable", 32'(stable_ok), 32'd1);
    chk("mem_quiet", 32'(quiet_ok), 32'd1);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; force_ack = 1'b0;
    mem_en = 1; mem_lat = 1;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_req", 32'({mem_req, mem_we}), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;

    // SB to the top byte lane
    txn(1, F3_B, 32'h103, 32'h000000AB, 32'h0, 0, 2, 0);
    chk("sb_addr", 32'(cap_addr), 32'h40);
    chk("sb_be", 32'(cap_be), 32'h8);
    chk("sb_wdata", cap_wdata, 32'hABABABAB);
    chk("sb_we", 32'(cap_we), 32'd1);
    chk("sb_req_cycles", 32'(req_cycles), 32'd1);

    // Byte loads, signed and unsigned
    txn(1, F3_W, 32'h100, 32'h00F00000, 32'h0, 0, 2, 0);
    chk("sw_be", 32'(cap_be), 32'hF);
    txn(0, F3_B,  32'h102, 32'h0, 32'hFFFFFFF0, 0, 2, 0);
    chk("lb_we", 32'(cap_we), 32'd0);
    txn(0, F3_BU, 32'h102, 32'h0, 32'h000000F0, 0, 2, 0);

    // Half loads from the upper lane
    txn(1, F3_W, 32'h100, 32'h80010000, 32'h0, 0, 2, 0);
    txn(0, F3_H,  32'h102, 32'h0, 32'hFFFF8001, 0, 2, 0);
    txn(0, F3_HU, 32'h102, 32'h0, 32'h00008001, 0, 2, 0);

    // Misaligned and illegal requests answer next cycle without touching memory
    txn(0, F3_W, 32'h101, 32'h0, 32'h0, 1, 1, 0);
    chk("misal_lw_no_req", 32'(req_cycles), 32'd0);
    txn(1, F3_H, 32'h101, 32'h1234, 32'h0, 1, 1, 0);
    chk("misal_sh_no_req", 32'(req_cycles), 32'd0);
    txn(1, 3'b011, 32'h0, 32'h0, 32'h0, 1, 1, 0);
    chk("illegal_st_no_req", 32'(req_cycles), 32'd0);
    txn(0, 3'b110, 32'h0, 32'h0, 32'h0, 1, 1, 0);
    chk("illegal_ld_no_req", 32'(req_cycles), 32'd0);

    // Timeout: no ack for TIMEOUT cycles, then a late ack must be ignored
    mem_en = 0;
    txn(0, F3_W, 32'h200, 32'h0, 32'h0, 1, TO + 1, 0);
    chk("to_req_cycles", 32'(req_cycles), 32'(TO));
    chk("to_addr", 32'(cap_addr), 32'h80);
    force_ack = 1'b1;
    @(negedge clk);
    chk("late_ack_no_resp", 32'(resp_valid), 32'd0);
    chk("late_ack_ready", 32'(req_ready), 32'd1);
    force_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_no_req", 32'({mem_req, resp_valid}), 32'd0);

    // Ack on the final timeout cycle is a success
    mem_en = 1; mem_lat = TO;
    txn(0, F3_W, 32'h100, 32'h0, 32'h80010000, 0, TO + 1, 0);
    chk("edge_req_cycles", 32'(req_cycles), 32'(TO));

    // Back-to-back store then load through a 3-cycle memory; load holds req_valid busy
    mem_lat = 3;
    txn(1, F3_W, 32'h10, 32'h12345678, 32'h0, 0, 4, 0);
    chk("sw3_req_cycles", 32'(req_cycles), 32'd3);
    txn(0, F3_W, 32'h10, 32'h0, 32'h12345678, 0, 4, 1);
    txn(0, F3_W, 32'h10, 32'h0, 32'h12345678, 0, 4, 0);

    // SH into upper half, read back
    mem_lat = 1;
    txn(1, F3_H, 32'h12, 32'h0000BEEF, 32'h0, 0, 2, 0);
    chk("sh_be", 32'(cap_be), 32'hC);
    chk("sh_wdata", cap_wdata, 32'hBEEFBEEF);
    txn(0, F3_HU, 32'h12, 32'h0, 32'h0000BEEF, 0, 2, 0);
    txn(0, F3_W,  32'h10, 32'h0, 32'hBEEF5678, 0, 2, 0);

    // Reset in the middle of a request
    mem_en = 0;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = F3_W; req_addr = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_mem_req", 32'(mem_req), 32'd0);
    chk("rst_async_resp", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("rst_hold_resp", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_ready", 32'(req_ready), 32'd1);
    chk("rst_rel_resp", 32'(resp_valid), 32'd0);
    mem_en = 1;
    txn(0, F3_W, 32'h10, 32'h0, 32'hBEEF5678, 0, 2, 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
